// File: rtl/i2s_sample_tx_pkg.sv
// Shared audio definitions for the I2S sample transmitter: default sample width,
// transmitter state encodings and the frame-length helper.
package i2s_sample_tx_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

  // One stereo frame carries the same word in both slots.
  function automatic int frame_bits(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with show-ahead read data and occupancy output.
// Push and pop may happen on the same clock; a push while full is ignored.
module sample_fifo
  import i2s_sample_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_AW:0]      level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (FIFO_AW + 1)'(1);
        2'b01:   level <= level - (FIFO_AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_tx.sv
// Philips-I2S transmitter: buffers mono samples and sends each one on both slots.
// Optional macro I2S_SAMPLE_TX_UNDERRUN_CNT_EN adds a saturating underrun_count output.
//
//  state   | meaning
//  ST_IDLE | bclk/lrclk/sdata held 0, divider held, waiting for en
//  ST_RUN  | bit clock running, one frame per 2*DATA_WIDTH bit periods
module i2s_sample_tx
  import i2s_sample_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underrun,
  output logic [FIFO_AW:0]      fifo_level
`ifdef I2S_SAMPLE_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int FRAME = frame_bits(DATA_WIDTH);
  localparam int NW    = $clog2(FRAME);
  localparam int DIV_W = $clog2(BCLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(BCLK_DIV - 1);
  localparam logic [NW-1:0]    LAST_BIT = NW'(FRAME - 1);
  localparam logic [NW-1:0]    LR_LO    = NW'(DATA_WIDTH - 1);
  localparam logic [NW-1:0]    LR_HI    = NW'(FRAME - 2);

  i2s_state_e            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [NW-1:0]         bit_q, bit_d;
  logic [FRAME-1:0]      shreg_q, shreg_d;
  logic                  first_q, first_d;
  logic                  bclk_d, lrclk_d, sdata_d, underrun_d;
  logic                  tc, shift_evt, frame_end;
  logic                  fifo_pop, fifo_full, fifo_empty, fifo_push;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  assign sample_ready = !fifo_full;
  assign fifo_push    = sample_valid && sample_ready;

  sample_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata(sample),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  assign tc        = (div_q == '0);
  assign shift_evt = (state_q == ST_RUN) && tc && i2s_bclk;
  // The first shift event after IDLE always loads; it is never a frame end.
  assign frame_end = shift_evt && !first_q && (bit_q == LAST_BIT);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    first_d    = first_q;
    bclk_d     = i2s_bclk;
    lrclk_d    = i2s_lrclk;
    sdata_d    = i2s_sdata;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d   = DIV_LOAD;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (en) begin
          state_d = ST_RUN;
          first_d = 1'b1;
        end
      end
      ST_RUN: begin
        div_d = tc ? DIV_LOAD : div_q - DIV_W'(1);
        if (tc) bclk_d = !i2s_bclk;
        if (shift_evt) begin
          first_d = 1'b0;
          if (frame_end && !en) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
          end else if (first_q || bit_q == LAST_BIT) begin
            bit_d   = '0;
            lrclk_d = 1'b0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = {fifo_rdata, fifo_rdata};
              sdata_d  = fifo_rdata[DATA_WIDTH-1];
            end else begin
              shreg_d    = '0;
              sdata_d    = 1'b0;
              underrun_d = 1'b1;
            end
          end else begin
            bit_d   = bit_q + NW'(1);
            shreg_d = shreg_q << 1;
            sdata_d = shreg_q[FRAME-2];
            lrclk_d = (bit_d >= LR_LO) && (bit_d <= LR_HI);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      first_q   <= 1'b0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      first_q   <= first_d;
      i2s_bclk  <= bclk_d;
      i2s_lrclk <= lrclk_d;
      i2s_sdata <= sdata_d;
      underrun  <= underrun_d;
    end
  end

`ifdef I2S_SAMPLE_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= '0;
    end else if (underrun && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
